sram_word_ctrl: RTL and testbench
=================================

SRAM_WORD_CTRL -- requirements
Module: sram_word_ctrl

Interface
REQ-001 Parameter DATA_W, 32, width of the pipeline data word; the block SHALL require DATA_W to be a multiple of SRAM_DW.
REQ-002 Parameter SRAM_DW, 16, SRAM data bus width.
REQ-003 Parameter SRAM_AW, 18, SRAM address bus width.
REQ-004 Parameter WAIT_CYCLES, 2, clock cycles per SRAM beat; the block SHALL require WAIT_CYCLES >= 2.
REQ-005 Parameter ADDR_BASE, 1024, byte address mapped to SRAM word 0.
REQ-006 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 rd_en  in  1  read request, held by the pipeline until ready.
REQ-009 wr_en  in  1  write request, held by the pipeline until ready.
REQ-010 address  in  32  byte address from the ALU.
REQ-011 writeData  in  DATA_W  store value.
REQ-012 readData  out  DATA_W  last completed read word.
REQ-013 ready  out  1  high when the pipeline may advance.
REQ-014 SRAM_DQ  inout  SRAM_DW  SRAM data bus.
REQ-015 SRAM_ADDR  out  SRAM_AW  SRAM address.
REQ-016 SRAM_UB_N, SRAM_LB_N, SRAM_CE_N  out  1 each  tied 0.
REQ-017 SRAM_WE_N  out  1  write strobe, active-low.
REQ-018 SRAM_OE_N  out  1  output enable, active-low.

Function
REQ-019 BEATS = DATA_W/SRAM_DW; the block SHALL hold a beat counter (0..BEATS-1) and a wait counter (0..WAIT_CYCLES-1).
REQ-020 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-021 IDLE: if wr_en or rd_en, the block SHALL latch address, writeData and op, move to ACCESS, and clear both counters; wr_en SHALL win when both are high.
REQ-022 ACCESS: the wait counter SHALL increment each cycle; at WAIT_CYCLES-1 it SHALL wrap to 0 and the beat counter SHALL increment; after the last cycle of beat BEATS-1 the FSM SHALL move to DONE.
REQ-023 DONE: the FSM SHALL return to IDLE unconditionally after one cycle, and SHALL ignore requests still held high in that cycle.
REQ-024 ready = (IDLE and not rd_en and not wr_en) or DONE, combinational.
REQ-025 Per request, ready SHALL be low for exactly 1 + BEATS*WAIT_CYCLES cycles, then high for one cycle (DONE); for defaults this is 5 low cycles.
REQ-026 Word index wa = (latched address - ADDR_BASE) >> log2(DATA_W/8), with the subtraction taken modulo 2^32.
REQ-027 SRAM_ADDR = (wa*BEATS + beat) mod 2^SRAM_AW, i.e. address wrap-around without error.
REQ-028 Beat b SHALL carry data bits [b*SRAM_DW +: SRAM_DW] (low half first).
REQ-029 Write ACCESS: SRAM_DQ SHALL be driven with the beat slice in every cycle of the beat, SRAM_WE_N SHALL be 0 for wait counts 0..WAIT_CYCLES-2, and 1 on the last wait count.
REQ-030 Read ACCESS: SRAM_OE_N SHALL be 0 and SRAM_DQ high-Z; at the last wait count of beat b, the block SHALL capture SRAM_DQ into an internal readData slice b.
REQ-031 readData SHALL update atomically on entry to DONE and hold until the next read completes; writes SHALL NOT alter it.
REQ-032 Outside ACCESS, SRAM_WE_N and SRAM_OE_N SHALL be 1, SRAM_DQ SHALL be high-Z, and SRAM_ADDR SHALL be 0.
REQ-033 Request inputs SHALL be sampled only in IDLE; changes during ACCESS SHALL have no effect.

Reset
REQ-034 On rst, in any state including mid-beat, the block SHALL set: state IDLE, counters 0, readData 0, SRAM_WE_N 1, SRAM_OE_N 1, SRAM_DQ high-Z, SRAM_ADDR 0.
REQ-035 An aborted write SHALL leave that beat undefined in SRAM; the block SHALL NOT retry it after reset.

Verification
REQ-036 Write 0xDEADBEEF to address 1024 (defaults) -> SRAM_ADDR 0 carries 0xBEEF, then 1 carries 0xDEAD, with WE_N low 1 cycle per beat; ready is low 5 cycles, then high 1 cycle.
REQ-037 Read address 1028 with SRAM model holding addr2=0x5678 and addr3=0x1234 -> readData = 0x12345678 on the DONE cycle, held afterwards.
REQ-038 rd_en and wr_en both high -> write sequence only; readData unchanged.
REQ-039 Assert rst during beat 1 of a write -> next cycle WE_N=1, DQ=Z, ready=1 with no request, readData=0.
REQ-040 Address 1020 (below base) -> SRAM_ADDR wraps to 2^18-2 and 2^18-1.
REQ-041 Re-parameterise DATA_W=64, WAIT_CYCLES=3 -> 4 beats, ready low 13 cycles, beat order low to high.

Source files
------------

// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: splits one pipeline data word into SRAM_DW-wide beats on an
// asynchronous SRAM, holding ready low until the whole word has been moved.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rd_en, wr_en        - pipeline read/write requests, held until ready
//   address, writeData  - byte address and store value
//   readData            - last completed read word (registered)
//   ready               - pipeline may advance (combinational)
//   SRAM_DQ/ADDR        - SRAM data bus and word address
//   SRAM_WE_N/OE_N      - active-low write strobe / output enable
//   SRAM_UB_N/LB_N/CE_N - byte lanes and chip enable, always asserted
module sram_word_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SRAM_DW     = 16,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_BASE   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [DATA_W-1:0]  writeData,
    output logic [DATA_W-1:0]  readData,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N
);

    localparam int unsigned BEATS  = DATA_W / SRAM_DW;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES);
    localparam int unsigned OFF_W  = $clog2(DATA_W / 8);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Elaboration-time parameter sanity checks
    if ((DATA_W % SRAM_DW) != 0 || DATA_W < SRAM_DW) begin : g_bad_dw
        $error("sram_word_ctrl: DATA_W must be a multiple of SRAM_DW");
    end
    if (WAIT_CYCLES < 2) begin : g_bad_wait
        $error("sram_word_ctrl: WAIT_CYCLES must be at least 2");
    end
    if (SRAM_AW > 32) begin : g_bad_aw
        $error("sram_word_ctrl: SRAM_AW must not exceed 32");
    end

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               op_wr;
    logic [31:0]        addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rd_buf;
    logic [DATA_W-1:0]  rd_buf_nxt;
    logic [SRAM_DW-1:0] wr_slice;
    logic [31:0]        word_idx;
    logic               req;
    logic               last_wait;
    logic               last_beat;
    logic               in_access;

    assign req       = rd_en | wr_en;
    assign last_wait = (wait_cnt == WAIT_W'(WAIT_CYCLES - 1));
    assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
    assign in_access = (state == S_ACCESS);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req) state_nxt = S_ACCESS;
            S_ACCESS: if (last_wait && last_beat) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Beat data selection: current write slice, and read buffer with the bus merged in
    always_comb begin
        wr_slice   = '0;
        rd_buf_nxt = rd_buf;
        for (int b = 0; b < int'(BEATS); b++) begin
            if (beat_cnt == BEAT_W'(b)) begin
                wr_slice                            = wdata_q[b*SRAM_DW +: SRAM_DW];
                rd_buf_nxt[b*SRAM_DW +: SRAM_DW]    = SRAM_DQ;
            end
        end
    end

    // Request latch, beat/wait counters and read capture
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            wait_cnt <= '0;
            op_wr    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_buf   <= '0;
            readData <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_q   <= address;
                        wdata_q  <= writeData;
                        op_wr    <= wr_en;
                        beat_cnt <= '0;
                        wait_cnt <= '0;
                    end
                end
                S_ACCESS: begin
                    if (last_wait) begin
                        wait_cnt <= '0;
                        beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
                        if (!op_wr) begin
                            rd_buf <= rd_buf_nxt;
                            // Whole word becomes visible together on entry to DONE
                            if (last_beat) readData <= rd_buf_nxt;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Word index relative to the base; the subtraction wraps below the base
    assign word_idx = (addr_q - 32'(ADDR_BASE)) >> OFF_W;

    // SRAM pins are decoded from registered state only
    assign SRAM_ADDR = in_access ? SRAM_AW'(word_idx * 32'(BEATS) + 32'(beat_cnt)) : '0;
    assign SRAM_WE_N = ~(in_access & op_wr & ~last_wait);
    assign SRAM_OE_N = ~(in_access & ~op_wr);
    assign SRAM_DQ   = (in_access & op_wr) ? wr_slice : {SRAM_DW{1'bz}};
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;

    assign ready = ((state == S_IDLE) && !req) || (state == S_DONE);

endmodule

// File: tb/tb_sram_word_ctrl.sv
// tb_sram_word_ctrl: directed bench for sram_word_ctrl with a default
// instance (32-bit word, 2 waits) and a 64-bit / 3-wait instance, each
// attached to a simple asynchronous SRAM model.
module tb_sram_word_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: defaults
    logic        rd_a, wr_a, ready_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    wire  [15:0] dq_a;
    logic [17:0] sa_a;
    logic        ub_a, lb_a, ce_a, we_a, oe_a;

    // Instance B: DATA_W=64, WAIT_CYCLES=3
    logic        rd_b, wr_b, ready_b;
    logic [31:0] addr_b;
    logic [63:0] wdata_b, rdata_b;
    wire  [15:0] dq_b;
    logic [17:0] sa_b;
    logic        ub_b, lb_b, ce_b, we_b, oe_b;

    sram_word_ctrl u_dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_a), .wr_en(wr_a), .address(addr_a),
        .writeData(wdata_a), .readData(rdata_a), .ready(ready_a), .SRAM_DQ(dq_a),
        .SRAM_ADDR(sa_a), .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a), .SRAM_CE_N(ce_a),
        .SRAM_WE_N(we_a), .SRAM_OE_N(oe_a)
    );

    sram_word_ctrl #(.DATA_W(64), .WAIT_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_b), .wr_en(wr_b), .address(addr_b),
        .writeData(wdata_b), .readData(rdata_b), .ready(ready_b), .SRAM_DQ(dq_b),
        .SRAM_ADDR(sa_b), .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b), .SRAM_CE_N(ce_b),
        .SRAM_WE_N(we_b), .SRAM_OE_N(oe_b)
    );

    // SRAM models
    logic [15:0] mem_a [0:262143];
    logic [15:0] mem_b [0:262143];
    assign dq_a = !oe_a ? mem_a[sa_a] : 16'bz;
    assign dq_b = !oe_b ? mem_b[sa_b] : 16'bz;
    always @(posedge clk) if (!we_a) mem_a[sa_a] <= dq_a;
    always @(posedge clk) if (!we_b) mem_b[sa_b] <= dq_b;

    // Bus monitors: one log entry {addr,data} per write beat, strobe/enable cycle counts
    logic [33:0] log_a[$];
    logic [33:0] log_b[$];
    int  we_low_a = 0, oe_low_a = 0, we_low_b = 0, oe_low_b = 0;
    logic we_prev_a = 1'b1, we_prev_b = 1'b1;
    always @(negedge clk) begin
        if (!we_a && we_prev_a) log_a.push_back({sa_a, dq_a});
        if (!we_b && we_prev_b) log_b.push_back({sa_b, dq_b});
        if (!we_a) we_low_a++;
        if (!oe_a) oe_low_a++;
        if (!we_b) we_low_b++;
        if (!oe_b) oe_low_b++;
        we_prev_a = we_a;
        we_prev_b = we_b;
    end

    int n_checks = 0;
    int n_errors = 0;
    int low_cnt, lb, wb, ob;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on instance sel and hold it until ready; ends on the DONE cycle.
    // Address/data are scrambled once the request is latched.
    task automatic do_req(input bit sel, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [63:0] d);
        @(negedge clk);
        lb = sel ? log_b.size() : log_a.size();
        wb = sel ? we_low_b : we_low_a;
        ob = sel ? oe_low_b : oe_low_a;
        if (sel) begin rd_b = rd; wr_b = wr; addr_b = a; wdata_b = d; end
        else     begin rd_a = rd; wr_a = wr; addr_a = a; wdata_a = d[31:0]; end
        #1;
        low_cnt = (sel ? ready_b : ready_a) ? 0 : 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sel) begin addr_b = 32'hFFFF_0000 ^ 32'(i); wdata_b = ~d; end
            else     begin addr_a = 32'hFFFF_0000 ^ 32'(i); wdata_a = ~d[31:0]; end
            @(negedge clk);
            if (sel ? ready_b : ready_a) break;
            low_cnt++;
        end
        if (sel) begin rd_b = 1'b0; wr_b = 1'b0; end
        else     begin rd_a = 1'b0; wr_a = 1'b0; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        rd_a = 0; wr_a = 0; addr_a = 0; wdata_a = 0;
        rd_b = 0; wr_b = 0; addr_b = 0; wdata_b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  64'(ready_a), 64'd1);
        check("rst_rdata",  64'(rdata_a), 64'd0);
        check("rst_we_n",   64'(we_a),    64'd1);
        check("rst_oe_n",   64'(oe_a),    64'd1);
        check("rst_addr",   64'(sa_a),    64'd0);
        check("rst_dq_hiz", 64'(dq_a === 16'hzzzz), 64'd1);
        check("tie_lo_a",   64'({ub_a, lb_a, ce_a}), 64'd0);
        check("tie_lo_b",   64'({ub_b, lb_b, ce_b}), 64'd0);
        check("rst_rdata_b", rdata_b, 64'd0);
        rst = 1'b0;

        // Write 0xDEADBEEF at the base address
        do_req(0, 0, 1, 32'd1024, 64'hDEADBEEF);
        check("wr1_low",   64'(low_cnt), 64'd5);
        check("wr1_done",  64'(ready_a), 64'd1);
        check("wr1_beats", 64'(log_a.size() - lb), 64'd2);
        check("wr1_b0",    64'(log_a[lb]),   64'({18'd0, 16'hBEEF}));
        check("wr1_b1",    64'(log_a[lb+1]), 64'({18'd1, 16'hDEAD}));
        check("wr1_we_cyc", 64'(we_low_a - wb), 64'd2);
        check("wr1_oe_cyc", 64'(oe_low_a - ob), 64'd0);
        check("wr1_rdata", 64'(rdata_a), 64'd0);

        // Store 0x12345678 at 1028 -> SRAM words 2 and 3
        do_req(0, 0, 1, 32'd1028, 64'h12345678);
        check("wr2_b0", 64'(log_a[lb]),   64'({18'd2, 16'h5678}));
        check("wr2_b1", 64'(log_a[lb+1]), 64'({18'd3, 16'h1234}));

        // Read it back
        do_req(0, 1, 0, 32'd1028, 64'd0);
        check("rd1_low",    64'(low_cnt), 64'd5);
        check("rd1_rdata",  64'(rdata_a), 64'h12345678);
        check("rd1_oe_cyc", 64'(oe_low_a - ob), 64'd4);
        check("rd1_we_cyc", 64'(we_low_a - wb), 64'd0);
        repeat (3) @(negedge clk);
        check("rd1_hold",   64'(rdata_a), 64'h12345678);
        check("idle_addr",  64'(sa_a), 64'd0);
        check("idle_dq_hiz", 64'(dq_a === 16'hzzzz), 64'd1);

        do_req(0, 1, 0, 32'd1024, 64'd0);
        check("rd2_rdata", 64'(rdata_a), 64'hDEADBEEF);

        // Both requests high: write wins, readData untouched
        do_req(0, 1, 1, 32'd1032, 64'hCAFEF00D);
        check("both_b0",    64'(log_a[lb]),   64'({18'd4, 16'hF00D}));
        check("both_b1",    64'(log_a[lb+1]), 64'({18'd5, 16'hCAFE}));
        check("both_oe",    64'(oe_low_a - ob), 64'd0);
        check("both_rdata", 64'(rdata_a), 64'hDEADBEEF);

        // Below the base: SRAM address wraps
        do_req(0, 0, 1, 32'd1020, 64'hAAAA5555);
        check("wrap_b0", 64'(log_a[lb]),   64'({18'h3FFFE, 16'h5555}));
        check("wrap_b1", 64'(log_a[lb+1]), 64'({18'h3FFFF, 16'hAAAA}));

        // Reset during beat 1 of a write
        @(negedge clk);
        wr_a = 1'b1; addr_a = 32'd1040; wdata_a = 32'h11112222;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_beat1_addr", 64'(sa_a), 64'd9);
        check("abort_beat1_we",   64'(we_a), 64'd0);
        rst = 1'b1; wr_a = 1'b0;
        @(negedge clk);
        check("abort_we_n",   64'(we_a), 64'd1);
        check("abort_dq_hiz", 64'(dq_a === 16'hzzzz), 64'd1);
        check("abort_ready",  64'(ready_a), 64'd1);
        check("abort_rdata",  64'(rdata_a), 64'd0);
        check("abort_addr",   64'(sa_a), 64'd0);
        rst = 1'b0;
        wb = we_low_a;
        repeat (4) @(negedge clk);
        check("abort_no_retry", 64'(we_low_a - wb), 64'd0);
        check("abort_idle_rdy", 64'(ready_a), 64'd1);

        // 64-bit word, 3 waits per beat
        do_req(1, 0, 1, 32'd1024, 64'h0123456789ABCDEF);
        check("w64_low",   64'(low_cnt), 64'd13);
        check("w64_beats", 64'(log_b.size() - lb), 64'd4);
        check("w64_b0",    64'(log_b[lb]),   64'({18'd0, 16'hCDEF}));
        check("w64_b1",    64'(log_b[lb+1]), 64'({18'd1, 16'h89AB}));
        check("w64_b2",    64'(log_b[lb+2]), 64'({18'd2, 16'h4567}));
        check("w64_b3",    64'(log_b[lb+3]), 64'({18'd3, 16'h0123}));
        check("w64_we_cyc", 64'(we_low_b - wb), 64'd8);

        do_req(1, 1, 0, 32'd1024, 64'd0);
        check("r64_low",    64'(low_cnt), 64'd13);
        check("r64_rdata",  rdata_b, 64'h0123456789ABCDEF);
        check("r64_oe_cyc", 64'(oe_low_b - ob), 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
